cordic_sincos_iter: RTL

- Parametrised iterative CORDIC in rotation mode. Returns both cos and sin of a signed fixed-point angle over the full [-pi, pi] range.
- Width, iteration count and iterations-per-cycle (unroll) are parameters. Input uses a start/busy/done handshake; clock enable stalls the block.
- Sits beside the floating-point units as the trig kernel. The fixed-point result feeds the float converter downstream.

---
 rtl/cordic_sincos_iter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC returning cos and sin of a signed fixed-point angle over [-pi, pi].
// Quadrant pre-rotation folds the angle into [-pi/2, pi/2]; UNROLL micro-rotations run per enabled clock.
module cordic_sincos_iter #(
    parameter int unsigned W      = 24,
    parameter int unsigned FRAC   = 21,
    parameter int unsigned ITERS  = 16,
    parameter int unsigned UNROLL = 4,
    parameter int unsigned GUARD  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clk_en,
    input  logic         start,
    input  logic [W-1:0] angle_in,
    output logic         busy,
    output logic         done,
    output logic         range_err,
    output logic [W-1:0] cos_out,
    output logic [W-1:0] sin_out
);

    localparam int unsigned WI = W + GUARD;
    localparam int unsigned FP = FRAC + GUARD;
    localparam int unsigned IW = $clog2(ITERS + UNROLL + 1);

    // Re-quantise a fixed-point constant from src to dst fractional bits, rounding to nearest.
    function automatic logic [63:0] rnd_shift(input logic [63:0] v, input int unsigned src,
                                              input int unsigned dst);
        if (dst >= src) return v << (dst - src);
        return (v + (64'd1 << (src - dst - 1))) >> (src - dst);
    endfunction

    localparam logic [63:0] PI_Q61 = 64'h6487_ED51_10B4_611A;
    localparam logic signed [W-1:0]  PI_FX      = W'(rnd_shift(PI_Q61, 61, FRAC));
    localparam logic signed [W-1:0]  HALF_PI_FX = W'(rnd_shift(PI_Q61, 62, FRAC));
    localparam logic signed [WI-1:0] K_FX       = WI'(rnd_shift(64'h9B74_EDA8, 32, FP));
    localparam logic signed [WI:0]   RND        = (WI+1)'((1 << GUARD) >> 1);

    localparam logic [63:0] ATAN32 [30] = '{
        64'hC90FDAA2, 64'h76B19C16, 64'h3EB6EBF2, 64'h1FD5BA9B, 64'h0FFAADDC,
        64'h07FF556F, 64'h03FFEAAB, 64'h01FFFD55, 64'h00FFFFAB, 64'h007FFFF5,
        64'h003FFFFF, 64'h00200000, 64'h00100000, 64'h00080000, 64'h00040000,
        64'h00020000, 64'h00010000, 64'h00008000, 64'h00004000, 64'h00002000,
        64'h00001000, 64'h00000800, 64'h00000400, 64'h00000200, 64'h00000100,
        64'h00000080, 64'h00000040, 64'h00000020, 64'h00000010, 64'h00000008
    };

    typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;

    state_t                 state_q, state_d;
    logic signed [WI-1:0]   x_q, y_q, z_q;
    logic signed [WI-1:0]   x_n, y_n, z_n, xs, ys;
    logic signed [WI-1:0]   atan_tab [30];
    logic [IW-1:0]          i_q;
    logic [5:0]             idx;
    logic                   neg_q, rerr_q, last_c;
    logic signed [W-1:0]    a_c, pre_c, cr_c, sr_c, cos_c, sin_c;
    logic                   pre_neg_c, pre_err_c;
    logic signed [WI:0]     xr_c, yr_c;

    // Arctangent table requantised to the internal fractional width.
    always_comb begin
        for (int k = 0; k < 30; k++) begin
            atan_tab[k] = WI'(rnd_shift(ATAN32[k], 32, FP));
        end
    end

    // Quadrant fold and range check on the incoming angle.
    always_comb begin
        a_c       = $signed(angle_in);
        pre_c     = a_c;
        pre_neg_c = 1'b0;
        if (a_c > HALF_PI_FX) begin
            pre_c     = a_c - PI_FX;
            pre_neg_c = 1'b1;
        end else if (a_c < -HALF_PI_FX) begin
            pre_c     = a_c + PI_FX;
            pre_neg_c = 1'b1;
        end
        pre_err_c = (a_c > PI_FX) || (a_c < -PI_FX);
    end

    // Chained micro-rotations for one enabled clock; lanes past ITERS pass through.
    always_comb begin
        x_n = x_q;
        y_n = y_q;
        z_n = z_q;
        xs  = '0;
        ys  = '0;
        idx = '0;
        for (int unsigned u = 0; u < UNROLL; u++) begin
            idx = 6'(32'(i_q) + u);
            if (32'(idx) < ITERS) begin
                xs = x_n >>> idx;
                ys = y_n >>> idx;
                if (z_n[WI-1]) begin
                    x_n = x_n + ys;
                    y_n = y_n - xs;
                    z_n = z_n + atan_tab[idx[4:0]];
                end else begin
                    x_n = x_n - ys;
                    y_n = y_n + xs;
                    z_n = z_n - atan_tab[idx[4:0]];
                end
            end
        end
    end

    assign last_c = (32'(i_q) + UNROLL) >= ITERS;

    // Round-half-up back to W bits, then undo the quadrant fold.
    always_comb begin
        xr_c  = (WI+1)'(x_q) + RND;
        yr_c  = (WI+1)'(y_q) + RND;
        cr_c  = W'(xr_c >>> GUARD);
        sr_c  = W'(yr_c >>> GUARD);
        cos_c = neg_q ? -cr_c : cr_c;
        sin_c = neg_q ? -sr_c : sr_c;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ROT;
            ROT:     if (last_c) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else if (clk_en) state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
            cos_out   <= '0;
            sin_out   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            i_q       <= '0;
            neg_q     <= 1'b0;
            rerr_q    <= 1'b0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        x_q    <= K_FX;
                        y_q    <= '0;
                        z_q    <= WI'(pre_c) <<< GUARD;
                        i_q    <= '0;
                        neg_q  <= pre_neg_c;
                        rerr_q <= pre_err_c;
                    end
                end
                ROT: begin
                    x_q <= x_n;
                    y_q <= y_n;
                    z_q <= z_n;
                    i_q <= last_c ? '0 : i_q + IW'(UNROLL);
                end
                OUT: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    range_err <= rerr_q;
                    cos_out   <= rerr_q ? '0 : cos_c;
                    sin_out   <= rerr_q ? '0 : sin_c;
                end
                default: ;
            endcase
        end
    end

endmodule
